elink_scrub_arbiter: RTL and testbench
======================================

Name: elink_scrub_arbiter

Overview:
- Shares the single read port of the triplicated-RAM elink trigger scrubber between two wishbone-style read masters.
- Round-robin arbitration, one outstanding transaction at a time.
- Schedules mandatory idle gaps so the scrubber's background scrub pass is never starved.
- Sits between the slow-control read masters and the scrubber's i_wb_* / o_wb_* port.

Parameters:
- ADDR_W, 4, address width; matches the scrubber address width.
- DATA_W, 10, read data width.
- MAX_BURST, 4, number of back-to-back completed grants allowed before a forced scrub gap.
- SCRUB_GAP, 5, cycles o_s_stb is held low per gap; covers one full scrub cycle of one address plus 1 cycle.
- TIMEOUT, 15, WAIT_ACK cycle limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- i_m0_stb  in  1  master 0 request; held high with address stable until o_m0_ack.
- i_m0_addr  in  ADDR_W  master 0 address.
- o_m0_stall  out  1  master 0 not accepted this cycle.
- o_m0_ack  out  1  master 0 one-cycle completion pulse.
- o_m0_data  out  DATA_W  master 0 read data; valid with o_m0_ack.
- i_m1_stb, i_m1_addr, o_m1_stall, o_m1_ack, o_m1_data: identical to the master 0 signals, for master 1.
- o_s_stb  out  1  request to the scrubber.
- o_s_addr  out  ADDR_W  address to the scrubber.
- i_s_stall  in  1  scrubber busy (scrub in progress).
- i_s_ack  in  1  scrubber read completion.
- i_s_data  in  DATA_W  scrubber read data.
- o_timeout  out  1  one-cycle pulse on an aborted transaction; tied 0 without the macro.

Behaviour:
- Reset: while rst_n is low at a clk edge, all state clears:
  - state=IDLE; o_s_stb=0, o_s_addr=0.
  - o_mX_ack=0, o_mX_data=0, o_timeout=0.
  - burst_cnt=0, gap_cnt=0, idle_cnt=0.
  - last_grant=1, so master 0 wins the first tie.
- Reset mid-transaction abandons it: no master ack, o_s_stb low on the next cycle.
- o_mX_stall is combinational:
  - forced 1 while rst_n is low;
  - otherwise 0 only when state==IDLE, burst_cnt<MAX_BURST, i_s_stall==0 and master X is the selected requester.
- Selection: a single requester wins. If both request, the winner is !last_grant.
- State IDLE:
  - burst_cnt==MAX_BURST -> GAP.
  - Else an accepted request (stb && !stall): o_s_stb<=1, o_s_addr<=winner address, grant<=winner, last_grant<=winner -> WAIT_ACK.
  - No stb: idle_cnt++. When idle_cnt reaches SCRUB_GAP, burst_cnt<=0 and idle_cnt<=0, since a natural gap counts as a scrub gap.
  - Any accept clears idle_cnt.
- State WAIT_ACK:
  - o_s_stb holds 1 until i_s_ack is sampled high.
  - On that edge: o_s_stb<=0; o_{grant}_data<=i_s_data; o_{grant}_ack<=1 for exactly one cycle; burst_cnt++ (saturating at MAX_BURST) -> IDLE.
- State GAP:
  - o_s_stb=0 and both stalls high, for exactly SCRUB_GAP cycles (gap_cnt counts 0..SCRUB_GAP-1).
  - On exit: burst_cnt<=0, gap_cnt<=0 -> IDLE.
- Latency: master stb accepted at edge t -> o_s_stb high from t+1. Scrubber ack at edge t+1+L -> master ack high in cycle t+2+L.
- An ack arriving without a pending grant (state!=WAIT_ACK) is ignored.
- i_s_stall is only consulted in IDLE; once issued, a request is held.
- The non-granted master's stb stays pending; it wins the next IDLE arbitration if still asserted, because of the round-robin rule.
- A master may reassert or keep stb in the cycle after its ack. It competes normally; no back-to-back issue happens in the same cycle as an ack.

Optional Feature:
- Macro ELINK_SCRUB_ARB_TIMEOUT_EN.
- Defined:
  - a 4-bit wait counter runs in WAIT_ACK;
  - if TIMEOUT cycles pass without i_s_ack: o_s_stb<=0, the granted master gets o_mX_ack=1 with o_mX_data={DATA_W{1'b1}} (10'h3FF), o_timeout pulses 1 cycle, burst_cnt++ -> IDLE.
- Not defined: no counter; WAIT_ACK waits indefinitely; o_timeout is constant 0.

Test Plan:
- Reset with m0 stb high, then release rst_n -> o_m0_stall=1 during reset; after release, a stub scrubber with L=3 gives o_s_stb in cycle t+1, o_s_addr=m0 addr, and o_m0_ack in cycle t+5 with the stub data (e.g. 10'h2A5).
- m0 and m1 request simultaneously and continuously -> grants alternate m0,m1,m0,m1; each master sees exactly one ack per grant with the correct data.
- Continuous requests with MAX_BURST=4 -> after 4 acks, o_s_stb stays low for exactly 5 cycles, then grants resume; a free-running scrubber model completes a scrub in that gap.
- i_s_stall held high for 3 cycles while m1 requests -> no o_s_stb and o_m1_stall=1 for those cycles; issue on the first cycle stall is low.
- rst_n asserted in WAIT_ACK -> no master ack; o_s_stb=0 next cycle; a late i_s_ack is ignored.
- With ELINK_SCRUB_ARB_TIMEOUT_EN and a scrubber stub that never acks -> after 15 cycles o_timeout pulses and o_m0_ack carries 10'h3FF. Without the macro, o_timeout stays 0 and the FSM remains in WAIT_ACK.

Source files
------------

// File: rtl/elink_scrub_arbiter.sv
// elink_scrub_arbiter: shares the single read port of the triplicated-RAM
// elink trigger scrubber between two read masters. Arbitration is round-robin
// with one outstanding read at a time. After MAX_BURST back-to-back reads a
// forced idle gap of SCRUB_GAP cycles lets the background scrub pass run.
// A natural idle stretch of SCRUB_GAP cycles counts as a gap.
// Optional feature: define ELINK_SCRUB_ARB_TIMEOUT_EN to abort reads the
// scrubber never acknowledges. An aborted read returns all-ones data and
// pulses o_timeout.

module elink_scrub_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 10,
    parameter int MAX_BURST = 4,
    parameter int SCRUB_GAP = 5,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_m0_stb,
    input  logic [ADDR_W-1:0] i_m0_addr,
    output logic              o_m0_stall,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_data,
    input  logic              i_m1_stb,
    input  logic [ADDR_W-1:0] i_m1_addr,
    output logic              o_m1_stall,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_data,
    output logic              o_s_stb,
    output logic [ADDR_W-1:0] o_s_addr,
    input  logic              i_s_stall,
    input  logic              i_s_ack,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_timeout
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int GAP_W   = $clog2(SCRUB_GAP + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(SCRUB_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        GAP
    } state_t;

    state_t              state;
    logic                grant;
    logic                last_grant;
    logic [BURST_W-1:0]  burst_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    idle_cnt;

    logic                any_req;
    logic                winner;
    logic                issue;
    logic                timed_out;
    logic                finish;
    logic [DATA_W-1:0]   finish_data;

`ifdef ELINK_SCRUB_ARB_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    logic [3:0] wait_cnt;
    logic       timeout_q;

    // Count cycles spent waiting for the scrubber so a lost ack cannot hang the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timed_out;
            if (state == WAIT_ACK && !finish) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign timed_out = (state == WAIT_ACK) && !i_s_ack && (wait_cnt == WAIT_LAST);
    assign o_timeout = timeout_q;
`else
    assign timed_out = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Pick the winner (round-robin on a tie) and decide whether a read can issue this cycle.
    always_comb begin
        any_req = i_m0_stb | i_m1_stb;
        if (i_m0_stb && i_m1_stb) begin
            winner = ~last_grant;
        end else begin
            winner = i_m1_stb;
        end
        issue       = (state == IDLE) && (burst_cnt < BURST_MAX) && !i_s_stall && any_req;
        finish      = (state == WAIT_ACK) && (i_s_ack || timed_out);
        finish_data = i_s_ack ? i_s_data : {DATA_W{1'b1}};
    end

    assign o_m0_stall = !rst_n || !(issue && !winner);
    assign o_m1_stall = !rst_n || !(issue && winner);

    // Main arbitration FSM: issue, wait for completion, and enforce scrub gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            idle_cnt   <= '0;
            o_s_stb    <= 1'b0;
            o_s_addr   <= '0;
            o_m0_ack   <= 1'b0;
            o_m1_ack   <= 1'b0;
            o_m0_data  <= '0;
            o_m1_data  <= '0;
        end else begin
            o_m0_ack <= 1'b0;
            o_m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_cnt == BURST_MAX) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (issue) begin
                        o_s_stb    <= 1'b1;
                        o_s_addr   <= winner ? i_m1_addr : i_m0_addr;
                        grant      <= winner;
                        last_grant <= winner;
                        idle_cnt   <= '0;
                        state      <= WAIT_ACK;
                    end else if (!any_req) begin
                        if (idle_cnt == GAP_LAST) begin
                            idle_cnt  <= '0;
                            burst_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (finish) begin
                        o_s_stb <= 1'b0;
                        if (grant) begin
                            o_m1_data <= finish_data;
                            o_m1_ack  <= 1'b1;
                        end else begin
                            o_m0_data <= finish_data;
                            o_m0_ack  <= 1'b1;
                        end
                        if (burst_cnt != BURST_MAX) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elink_scrub_arbiter.sv
// tb_elink_scrub_arbiter: directed bench for elink_scrub_arbiter with a
// scrubber stub that acks a fixed number of cycles after o_s_stb rises.
// Returned data is stub_base | address.

module tb_elink_scrub_arbiter;

    logic       clk;
    logic       rst_n;
    logic       i_m0_stb;
    logic [3:0] i_m0_addr;
    logic       o_m0_stall;
    logic       o_m0_ack;
    logic [9:0] o_m0_data;
    logic       i_m1_stb;
    logic [3:0] i_m1_addr;
    logic       o_m1_stall;
    logic       o_m1_ack;
    logic [9:0] o_m1_data;
    logic       o_s_stb;
    logic [3:0] o_s_addr;
    logic       i_s_stall;
    logic       i_s_ack;
    logic [9:0] i_s_data;
    logic       o_timeout;

    int         compared   = 0;
    int         mismatched = 0;

    bit         stub_on   = 0;
    int         stub_lat  = 0;
    int         stub_age  = 0;
    logic [9:0] stub_base = '0;

    elink_scrub_arbiter #(
        .ADDR_W    (4),
        .DATA_W    (10),
        .MAX_BURST (4),
        .SCRUB_GAP (5),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_m0_stb   (i_m0_stb),
        .i_m0_addr  (i_m0_addr),
        .o_m0_stall (o_m0_stall),
        .o_m0_ack   (o_m0_ack),
        .o_m0_data  (o_m0_data),
        .i_m1_stb   (i_m1_stb),
        .i_m1_addr  (i_m1_addr),
        .o_m1_stall (o_m1_stall),
        .o_m1_ack   (o_m1_ack),
        .o_m1_data  (o_m1_data),
        .o_s_stb    (o_s_stb),
        .o_s_addr   (o_s_addr),
        .i_s_stall  (i_s_stall),
        .i_s_ack    (i_s_ack),
        .i_s_data   (i_s_data),
        .o_timeout  (o_timeout)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic m0_stb, input logic [3:0] m0_addr,
                                 input logic m1_stb, input logic [3:0] m1_addr);
        i_m0_stb  = m0_stb;
        i_m0_addr = m0_addr;
        i_m1_stb  = m1_stb;
        i_m1_addr = m1_addr;
    endtask

    task automatic stubStep();
        if (stub_on && o_s_stb) begin
            i_s_ack  = (stub_age == stub_lat);
            i_s_data = stub_base | 10'(o_s_addr);
            stub_age++;
        end else begin
            i_s_ack  = 1'b0;
            stub_age = 0;
        end
    endtask

    // Advance one clock edge, update the scrubber stub, and leave time for outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
        stubStep();
        #1;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        stub_on = 0;
        i_s_ack = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic waitAck(input string tag, input int exp_m, input logic [3:0] exp_addr,
                           input logic [9:0] exp_data, input bit release_stb);
        bit seen;
        int c;
        seen = 0;
        c    = 0;
        while (!(o_m0_ack || o_m1_ack) && c < 40) begin
            if (o_s_stb && !seen) begin
                seen = 1;
                checkOutput({tag, "_addr"}, o_s_addr, exp_addr);
            end
            tick();
            c++;
        end
        checkOutput({tag, "_issued"}, seen, 1);
        checkOutput({tag, "_m0_ack"}, o_m0_ack, exp_m == 0);
        checkOutput({tag, "_m1_ack"}, o_m1_ack, exp_m == 1);
        checkOutput({tag, "_data"}, (exp_m == 1) ? o_m1_data : o_m0_data, exp_data);
        if (release_stb) begin
            if (exp_m == 1) i_m1_stb = 1'b0;
            else            i_m0_stb = 1'b0;
        end
        tick();
        checkOutput({tag, "_pulse"}, o_m0_ack | o_m1_ack, 0);
    endtask

    task automatic lowRun(input string tag, input int expected);
        int n;
        n = 0;
        while (!o_s_stb && n < 40) begin
            n++;
            tick();
        end
        checkOutput(tag, n, expected);
    endtask

    // Directed sequence covering reset, latency, round-robin, gaps, stall, abort and timeout.
    initial begin
        rst_n     = 1'b0;
        i_s_stall = 1'b0;
        i_s_ack   = 1'b0;
        i_s_data  = '0;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);

        // Reset with m0 requesting, then latency with a 3-cycle scrubber.
        $display("[TB] reset and latency");
        applyStimulus(1'b1, 4'h5, 1'b0, 4'h0);
        tick();
        tick();
        checkOutput("rst_m0_stall", o_m0_stall, 1);
        checkOutput("rst_s_stb", o_s_stb, 0);
        checkOutput("rst_s_addr", o_s_addr, 0);
        checkOutput("rst_m0_ack", o_m0_ack, 0);
        checkOutput("rst_m0_data", o_m0_data, 0);
        checkOutput("rst_timeout", o_timeout, 0);
        rst_n     = 1'b1;
        stub_on   = 1;
        stub_lat  = 3;
        stub_base = 10'h2A0;
        #1;
        checkOutput("lat_m0_stall", o_m0_stall, 0);
        checkOutput("lat_m1_stall", o_m1_stall, 1);
        tick();
        checkOutput("lat_s_stb", o_s_stb, 1);
        checkOutput("lat_s_addr", o_s_addr, 4'h5);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("lat_early_ack", o_m0_ack, 0);
        end
        tick();
        checkOutput("lat_m0_ack", o_m0_ack, 1);
        checkOutput("lat_m0_data", o_m0_data, 10'h2A5);
        checkOutput("lat_s_stb_low", o_s_stb, 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        tick();
        checkOutput("lat_ack_pulse", o_m0_ack, 0);

        // Both masters request continuously: m0,m1,m0,m1, then a forced gap, then m0 again.
        $display("[TB] round-robin and forced gap");
        applyStimulus(1'b1, 4'h3, 1'b1, 4'hC);
        doReset();
        stub_on   = 1;
        stub_lat  = 1;
        stub_base = 10'h100;
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 1) waitAck($sformatf("alt%0d", g), 1, 4'hC, 10'h10C, 0);
            else            waitAck($sformatf("alt%0d", g), 0, 4'h3, 10'h103, 0);
        end
        checkOutput("gap_m0_stall", o_m0_stall, 1);
        checkOutput("gap_m1_stall", o_m1_stall, 1);
        // Five gap cycles plus the re-arbitration cycle every issue needs.
        lowRun("gap_len", 6);
        waitAck("post_gap", 0, 4'h3, 10'h103, 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);

        // Five idle cycles after three reads clear the burst count, so no gap after the fourth read.
        $display("[TB] natural idle gap");
        applyStimulus(1'b1, 4'h1, 1'b0, 4'h0);
        doReset();
        stub_on   = 1;
        stub_lat  = 0;
        stub_base = 10'h040;
        waitAck("nat1", 0, 4'h1, 10'h041, 0);
        waitAck("nat2", 0, 4'h1, 10'h041, 0);
        waitAck("nat3", 0, 4'h1, 10'h041, 1);
        repeat (4) tick();
        i_m0_stb = 1'b1;
        waitAck("nat4", 0, 4'h1, 10'h041, 0);
        lowRun("nat_no_gap", 0);
        waitAck("nat5", 0, 4'h1, 10'h041, 1);

        // Scrubber busy for three cycles while m1 requests.
        $display("[TB] scrubber stall");
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h6);
        doReset();
        i_s_stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_m1_stall", o_m1_stall, 1);
            tick();
            checkOutput("stall_s_stb", o_s_stb, 0);
        end
        i_s_stall = 1'b0;
        #1;
        checkOutput("stall_release", o_m1_stall, 0);
        stub_on   = 1;
        stub_lat  = 2;
        stub_base = 10'h1C0;
        tick();
        checkOutput("stall_issue", o_s_stb, 1);
        i_s_stall = 1'b1;
        waitAck("stall_txn", 1, 4'h6, 10'h1C6, 1);
        i_s_stall = 1'b0;

        // Reset in WAIT_ACK abandons the read; a late ack is ignored.
        $display("[TB] reset during wait");
        applyStimulus(1'b1, 4'h7, 1'b0, 4'h0);
        doReset();
        tick();
        checkOutput("abort_s_stb", o_s_stb, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_stall_forced", o_m0_stall, 1);
        tick();
        checkOutput("abort_s_stb_low", o_s_stb, 0);
        checkOutput("abort_no_ack", o_m0_ack, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        i_s_data = 10'h3C3;
        i_s_ack  = 1'b1;
        tick();
        checkOutput("late_m0_ack", o_m0_ack, 0);
        checkOutput("late_m1_ack", o_m1_ack, 0);
        checkOutput("late_m0_data", o_m0_data, 0);
        checkOutput("late_s_stb", o_s_stb, 0);

        // Scrubber that never acks.
        $display("[TB] missing ack");
        applyStimulus(1'b1, 4'hA, 1'b0, 4'h0);
        doReset();
        tick();
        checkOutput("hang_s_stb", o_s_stb, 1);
`ifdef ELINK_SCRUB_ARB_TIMEOUT_EN
        for (int k = 1; k < 15; k++) begin
            tick();
            checkOutput("to_early_ack", o_m0_ack, 0);
            checkOutput("to_early_flag", o_timeout, 0);
        end
        tick();
        checkOutput("to_m0_ack", o_m0_ack, 1);
        checkOutput("to_m0_data", o_m0_data, 10'h3FF);
        checkOutput("to_flag", o_timeout, 1);
        checkOutput("to_s_stb", o_s_stb, 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        tick();
        checkOutput("to_flag_pulse", o_timeout, 0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("hang_s_stb_held", o_s_stb, 1);
            checkOutput("hang_no_timeout", o_timeout, 0);
        end
        checkOutput("hang_no_ack", o_m0_ack, 0);
        checkOutput("hang_m0_stall", o_m0_stall, 1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
